// File: rtl/multimode_ring_counter.sv
// Ring / Johnson / one-cold counter with load, direction and self-correction of illegal states.
// One-cycle registered latency on count/wrap/err; en gates stepping, no further backpressure.
module multimode_ring_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             err
);

    localparam logic [1:0]       MODE_RING = 2'b00;
    localparam logic [1:0]       MODE_JOHN = 2'b01;
    localparam logic [1:0]       MODE_COLD = 2'b10;
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       mode_q, mode_d, mode_dec;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stepped;

    function automatic logic [WIDTH-1:0] init_pat(input logic [1:0] m);
        case (m)
            MODE_JOHN: return '0;
            MODE_COLD: return {{(WIDTH-1){1'b1}}, 1'b0};
            default:   return ONE;
        endcase
    endfunction

    function automatic logic one_hot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - ONE)) == '0);
    endfunction

    // True for 0..01..1 (including all-zeros and all-ones).
    function automatic logic low_ones(input logic [WIDTH-1:0] v);
        return (v & (v + ONE)) == '0;
    endfunction

    function automatic logic is_legal(input logic [1:0] m, input logic [WIDTH-1:0] v);
        case (m)
            MODE_JOHN: return low_ones(v) || low_ones(~v);
            MODE_COLD: return one_hot(~v);
            default:   return one_hot(v);
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] step(input logic [1:0] m, input logic d,
                                              input logic [WIDTH-1:0] v);
        if (m == MODE_JOHN) begin
            return d ? {~v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], ~v[WIDTH-1]};
        end
        return d ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    // Reserved encoding 11 runs as a plain ring counter.
    assign mode_dec = (mode == 2'b11) ? MODE_RING : mode;
    assign stepped  = step(mode_q, dir, count_q);

    always_comb begin
        mode_d  = mode_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (mode_dec != mode_q) begin
            mode_d  = mode_dec;
            count_d = init_pat(mode_dec);
        end else if (load) begin
            if (is_legal(mode_q, load_val)) begin
                count_d = load_val;
            end else begin
                count_d = init_pat(mode_q);
                err_d   = 1'b1;
            end
        end else if (!is_legal(mode_q, count_q)) begin
            count_d = init_pat(mode_q);
            err_d   = 1'b1;
        end else if (en) begin
            count_d = stepped;
            wrap_d  = (stepped == init_pat(mode_q));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_RING;
            count_q <= ONE;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        count = count_q;
        wrap  = wrap_q;
        err   = err_q;
    end

endmodule

// File: tb/tb_multimode_ring_counter.sv
// Directed plus random bench; the reference model walks an explicit per-mode sequence table by index.
module tb_multimode_ring_counter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, en, dir, load;
    logic [1:0]   mode;
    logic [W-1:0] load_val, count;
    logic         wrap, err;

    int checks = 0, passes = 0, fails = 0;

    int           m_mode;
    logic [W-1:0] m_cnt;
    logic         m_wrap, m_err;

    multimode_ring_counter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_val(load_val), .count(count), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    // Element idx of the mode's sequence; element 0 is the init pattern.
    function automatic logic [W-1:0] seq_at(input int md, input int idx);
        int v;
        if (md == 1) v = (idx <= W) ? ((1 << idx) - 1) : (((1 << W) - 1) << (idx - W));
        else if (md == 2) v = ~(1 << idx);
        else v = 1 << idx;
        return v[W-1:0];
    endfunction

    function automatic int period(input int md);
        return (md == 1) ? 2 * W : W;
    endfunction

    function automatic int index_of(input int md, input logic [W-1:0] v);
        for (int i = 0; i < period(md); i++) if (seq_at(md, i) == v) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = seq_at(0, 0); m_wrap = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_clk();
        int dm, idx, p;
        dm = (mode == 2'b11) ? 0 : int'(mode);
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (dm != m_mode) begin
            m_mode = dm;
            m_cnt  = seq_at(dm, 0);
        end else if (load) begin
            if (index_of(m_mode, load_val) >= 0) m_cnt = load_val;
            else begin m_cnt = seq_at(m_mode, 0); m_err = 1'b1; end
        end else if (index_of(m_mode, m_cnt) < 0) begin
            m_cnt = seq_at(m_mode, 0);
            m_err = 1'b1;
        end else if (en) begin
            p      = period(m_mode);
            idx    = index_of(m_mode, m_cnt);
            idx    = dir ? (idx + p - 1) % p : (idx + 1) % p;
            m_cnt  = seq_at(m_mode, idx);
            m_wrap = (idx == 0);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs compared.
    task automatic cyc(input logic e, input logic d, input logic [1:0] md,
                       input logic ld, input logic [W-1:0] lv);
        en = e; dir = d; mode = md; load = ld; load_val = lv;
        @(posedge clk);
        model_clk();
        @(negedge clk);
        check("count", count, m_cnt);
        check("wrap", W'(wrap), W'(m_wrap));
        check("err", W'(err), W'(m_err));
    endtask

    logic [W-1:0] e28 [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [W-1:0] e29 [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                              4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [W-1:0] e30 [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    initial begin
        int rm, pm;
        reset = 1'b1; en = 1'b0; dir = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("reset_count", count, 4'b0001);
        check("reset_wrap", W'(wrap), '0);
        check("reset_err", W'(err), '0);
        reset = 1'b0;

        // Ring rotation left with wrap on the return to 0001
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 2'b00, 0, '0);
            check("ring_seq", count, e28[i]);
            check("ring_wrap", W'(wrap), W'(i == 3));
        end

        cyc(1, 0, 2'b01, 0, '0);
        check("to_johnson", count, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 2'b01, 0, '0);
            check("john_seq", count, e29[i]);
            check("john_wrap", W'(wrap), W'(i == 7));
        end

        cyc(1, 1, 2'b00, 0, '0);
        check("to_ring", count, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 2'b00, 0, '0);
            check("ring_right", count, e30[i]);
        end
        cyc(1, 1, 2'b10, 0, '0);
        check("to_cold", count, 4'b1110);
        cyc(1, 0, 2'b10, 0, '0);
        check("cold_left", count, 4'b1101);

        cyc(0, 0, 2'b00, 0, '0);
        cyc(0, 0, 2'b00, 1, 4'b0101);
        check("bad_load", count, 4'b0001);
        check("bad_load_err", W'(err), 4'b0001);
        cyc(0, 0, 2'b00, 1, 4'b0100);
        check("good_load", count, 4'b0100);
        check("good_load_err", W'(err), '0);
        cyc(0, 0, 2'b00, 0, '0);
        check("hold", count, 4'b0100);

        cyc(1, 0, 2'b01, 1, 4'b0011);
        check("mode_beats_load", count, 4'b0000);
        cyc(1, 0, 2'b01, 1, 4'b0011);
        check("john_load", count, 4'b0011);
        cyc(1, 0, 2'b11, 0, '0);
        check("reserved_as_ring", count, 4'b0001);

        // Async reset from Johnson 0111, observed before the next clock edge
        cyc(1, 0, 2'b01, 0, '0);
        cyc(1, 0, 2'b01, 0, '0);
        cyc(1, 0, 2'b01, 0, '0);
        cyc(1, 0, 2'b01, 0, '0);
        check("john_0111", count, 4'b0111);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_count", count, 4'b0001);
        check("async_wrap", W'(wrap), '0);
        check("async_err", W'(err), '0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 0, 2'b00, 0, '0);
        check("post_reset_ring", count, 4'b0010);

        reset = 1'b1;
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        cyc(1, 0, 2'b10, 0, '0);
        check("first_edge_mode", count, 4'b1110);

        rm = 2;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) rm = $urandom_range(0, 3);
            pm = (rm == 3) ? 0 : rm;
            if ($urandom_range(0, 1) == 1)
                load_val = seq_at(pm, $urandom_range(0, period(pm) - 1));
            else
                load_val = W'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'(rm),
                1'($urandom_range(0, 7) == 0), load_val);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/multimode_ring_counter.md
MULTIMODE_RING_COUNTER -- requirements
Module: multimode_ring_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port en  input  1  step enable; 1 = advance one position per clock.
REQ-005 SHALL have port dir  input  1  step direction; 0 = rotate toward MSB, 1 = rotate toward LSB.
REQ-006 SHALL have port mode  input  2  00 = ring (one-hot), 01 = Johnson, 10 = one-cold, 11 = reserved.
REQ-007 SHALL have port load  input  1  synchronous load request.
REQ-008 SHALL have port load_val  input  WIDTH  pattern to load.
REQ-009 SHALL have port count  output  WIDTH  registered counter state.
REQ-010 SHALL have port wrap  output  1  registered one-cycle pulse when the sequence returns to its init pattern.
REQ-011 SHALL have port err  output  1  registered one-cycle pulse on a rejected load or an illegal-state correction.

Function
REQ-012 SHALL define the init pattern per mode: ring 0..01, Johnson 0..00, one-cold 1..10.
REQ-013 SHALL define legal states per mode: ring = exactly one 1; one-cold = exactly one 0; Johnson = 0..01..1 or 1..10..0 forms, i.e. the 2*WIDTH reachable states.
REQ-014 SHALL hold the active mode in an internal register mode_q; mode input 11 SHALL be treated as 00.
REQ-015 SHALL evaluate actions in this priority each clock: mode change, then load, then illegal-state correction, then step, then hold.
REQ-016 On a mode change (decoded mode != mode_q), SHALL set mode_q to the new mode and count to the new init pattern, with wrap = 0 and err = 0, regardless of en and load.
REQ-017 On load with load_val legal for mode_q, SHALL set count to load_val with err = 0.
REQ-018 On load with illegal load_val, SHALL set count to the init pattern and pulse err for one cycle.
REQ-019 With no load and count illegal for mode_q, SHALL set count to the init pattern and pulse err, independent of en.
REQ-020 Ring and one-cold steps: dir = 0 SHALL rotate left ({count[W-2:0], count[W-1]}); dir = 1 SHALL rotate right.
REQ-021 Johnson step: dir = 0 SHALL produce {count[W-2:0], ~count[W-1]}; dir = 1 SHALL produce {~count[0], count[W-1:1]}.
REQ-022 SHALL assert wrap in the cycle after a step whose result equals the init pattern; wrap SHALL NOT assert on load, mode change, or correction.
REQ-023 With en = 0 and no other action, SHALL hold count, and wrap and err SHALL be 0.
REQ-024 Changing dir SHALL take effect on the same clock edge, with no dead cycle.
REQ-025 Period SHALL be WIDTH steps for ring and one-cold, and 2*WIDTH steps for Johnson.

Reset
REQ-026 While reset = 1, SHALL immediately and without a clock force count = 0..01, mode_q = 00, wrap = 0, err = 0.
REQ-027 After reset deasserts, SHALL act on the first rising clock edge; a mode input other than 00 at that edge SHALL be treated as a mode change.

Verification (WIDTH = 4)
REQ-028 Reset, mode = 00, en = 1, dir = 0 -> count 0001, 0010, 0100, 1000, 0001; wrap = 1 only in the cycle showing 0001 after 1000.
REQ-029 mode 00 -> 01 with en = 1 -> count 0000 (err = 0), then 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 with wrap = 1.
REQ-030 Ring at 0001, dir = 1 -> 1000, 0100, 0010, 0001 (wrap = 1); mode = 10 -> 1110, then 1101 with dir = 0.
REQ-031 Ring, load = 1, load_val = 0101 -> count 0001, err = 1 for one cycle; load_val = 0100 with en = 0 -> count 0100, err = 0.
REQ-032 Same cycle: mode 00 -> 01 and load = 1 with load_val = 0011 -> count 0000 (mode wins); next cycle load 0011 -> 0011.
REQ-033 Reset asserted mid-operation between clock edges in Johnson at 0111 -> count 0001 and mode_q = 00 before the next edge; wrap and err stay 0.
